// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic-light controller input front-end.
package traffic_pkg;

  localparam int NUM_CAR             = 4;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int STUCK_CYCLES_DEF    = 4096;

  typedef logic [NUM_CAR-1:0] car_vec_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One sensor line: synchroniser chain, debounce counter, stable level and
// a registered one-cycle pulse on each debounced rising edge.
module debounce_channel
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_s;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;
  logic                   rise_reg;

  // Pure flop chain: nothing may sit between the synchroniser stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      if (sync_s == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync_s;
        cnt_reg   <= '0;
        rise_reg  <= sync_s;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the car-loop sensors and pedestrian button for the controller,
// and flags any car channel whose debounced level stays high too long.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic     clock,
  input  logic     reset,
  input  car_vec_t car_raw,
  input  logic     button_raw,
  input  logic     fault_clr,
  output car_vec_t car_present,
  output car_vec_t car_arrive,
  output logic     button_pulse,
  output logic     button_level,
  output car_vec_t stuck_fault
);

  localparam int            SW      = cnt_width(STUCK_CYCLES);
  localparam logic [SW-1:0] SC_LAST = SW'(STUCK_CYCLES - 1);

  car_vec_t      car_level;
  car_vec_t      car_rise;
  car_vec_t      stuck_reg;
  logic [SW-1:0] sc_reg [NUM_CAR];

  generate
    for (genvar gi = 0; gi < NUM_CAR; gi++) begin : g_car
      debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
        .clock (clock),
        .reset (reset),
        .raw   (car_raw[gi]),
        .level (car_level[gi]),
        .rise  (car_rise[gi])
      );

      // Saturating high-time counter; a clear request beats a new fault.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sc_reg[gi]    <= '0;
          stuck_reg[gi] <= 1'b0;
        end else if (fault_clr) begin
          sc_reg[gi]    <= '0;
          stuck_reg[gi] <= 1'b0;
        end else begin
          if (!car_level[gi]) begin
            sc_reg[gi] <= '0;
          end else if (sc_reg[gi] != SC_LAST) begin
            sc_reg[gi] <= sc_reg[gi] + SW'(1);
          end
          if (car_level[gi] && (sc_reg[gi] == SC_LAST)) begin
            stuck_reg[gi] <= 1'b1;
          end
        end
      end

      // A faulted approach is always reported present, never newly arriving.
      assign car_present[gi] = car_level[gi] | stuck_reg[gi];
      assign car_arrive[gi]  = car_rise[gi] & ~stuck_reg[gi];
    end
  endgenerate

  debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button (
    .clock (clock),
    .reset (reset),
    .raw   (button_raw),
    .level (button_level),
    .rise  (button_pulse)
  );

  assign stuck_fault = stuck_reg;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with a sample-window reference model.
module tb_sensor_conditioner;
  import traffic_pkg::*;

  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int ST  = 20;
  localparam int NCH = NUM_CAR + 1;
  localparam int HL  = SS + DB;

  logic     clock = 1'b0;
  logic     reset;
  car_vec_t car_raw;
  logic     button_raw;
  logic     fault_clr;
  car_vec_t car_present;
  car_vec_t car_arrive;
  logic     button_pulse;
  logic     button_level;
  car_vec_t stuck_fault;

  sensor_conditioner #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .STUCK_CYCLES    (ST)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .car_raw      (car_raw),
    .button_raw   (button_raw),
    .fault_clr    (fault_clr),
    .car_present  (car_present),
    .car_arrive   (car_arrive),
    .button_pulse (button_pulse),
    .button_level (button_level),
    .stuck_fault  (stuck_fault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: hist[c][j] is the raw value sampled j+1 edges ago.
  // The stable level toggles when the last DB synchronised samples all
  // disagree with it; a car faults after ST consecutive edges seeing it high.
  logic hist [NCH][HL];
  logic mq    [NCH];
  logic mrise [NCH];
  logic mfault[NUM_CAR];
  int   run   [NUM_CAR];
  logic m_raw, m_diff;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
        mq[c]    = 1'b0;
        mrise[c] = 1'b0;
      end
      for (int c = 0; c < NUM_CAR; c++) begin
        mfault[c] = 1'b0;
        run[c]    = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CAR; c++) begin
        if (fault_clr) begin
          run[c]    = 0;
          mfault[c] = 1'b0;
        end else if (mq[c]) begin
          run[c]++;
          if (run[c] >= ST) mfault[c] = 1'b1;
        end else begin
          run[c] = 0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        m_raw  = (c < NUM_CAR) ? car_raw[c] : button_raw;
        m_diff = 1'b1;
        for (int k = 0; k < DB; k++)
          if (hist[c][SS-1+k] == mq[c]) m_diff = 1'b0;
        mrise[c] = m_diff & ~mq[c];
        if (m_diff) mq[c] = ~mq[c];
        for (int j = HL-1; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = m_raw;
      end
    end
  end

  car_vec_t e_present, e_arrive, e_fault;

  always @(negedge clock) begin
    for (int c = 0; c < NUM_CAR; c++) begin
      e_present[c] = mq[c] | mfault[c];
      e_arrive[c]  = mrise[c] & ~mfault[c];
      e_fault[c]   = mfault[c];
    end
    chk("cyc_car_present", car_present, e_present);
    chk("cyc_car_arrive", car_arrive, e_arrive);
    chk("cyc_stuck_fault", stuck_fault, e_fault);
    chk("cyc_button_level", button_level, mq[NUM_CAR]);
    chk("cyc_button_pulse", button_pulse, mrise[NUM_CAR]);
  end

  int pulses;
  int lvl_seen;

  initial begin
    reset      = 1'b1;
    car_raw    = 4'hF;
    button_raw = 1'b1;
    fault_clr  = 1'b0;

    // Reset with every raw line high, then five quiet edges after release.
    repeat (3) @(negedge clock);
    chk("rst_hold_outputs", {car_present, car_arrive, stuck_fault, button_level, button_pulse}, 0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("rst_release_quiet", {car_present, car_arrive, stuck_fault, button_level, button_pulse}, 0);
    end
    @(negedge clock);
    chk("rst_all_present", car_present, 4'hF);
    chk("rst_all_arrive", car_arrive, 4'hF);
    chk("rst_btn_pulse", button_pulse, 1'b1);
    @(negedge clock);
    chk("rst_arrive_once", car_arrive, 4'h0);
    car_raw    = 4'h0;
    button_raw = 1'b0;
    repeat (10) @(negedge clock);
    chk("rst_all_released", car_present, 4'h0);

    // Clean car1 step.
    car_raw[0] = 1'b1;
    repeat (5) @(negedge clock);
    chk("car1_not_yet", car_present, 4'h0);
    @(negedge clock);
    chk("car1_present", car_present, 4'b0001);
    chk("car1_arrive", car_arrive, 4'b0001);
    @(negedge clock);
    chk("car1_arrive_once", car_arrive, 4'h0);
    chk("car1_hold", car_present, 4'b0001);
    car_raw[0] = 1'b0;
    repeat (10) @(negedge clock);

    // Button: 3-cycle glitch rejected, 5-cycle press accepted once.
    pulses = 0; lvl_seen = 0;
    button_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      pulses   += int'(button_pulse);
      lvl_seen += int'(button_level);
      if (k == 3) button_raw = 1'b0;
    end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_level", lvl_seen, 0);
    pulses = 0;
    button_raw = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      pulses += int'(button_pulse);
      if (k == 5) button_raw = 1'b0;
    end
    chk("press5_pulses", pulses, 1);

    // Car3 (index 2) bounce: high 3, low 1, then steady high.
    pulses = 0;
    car_raw[2] = 1'b1;
    repeat (3) begin @(negedge clock); pulses += int'(car_arrive[2]); end
    car_raw[2] = 1'b0;
    @(negedge clock); pulses += int'(car_arrive[2]);
    car_raw[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      pulses += int'(car_arrive[2]);
      if (k == 5) chk("bounce_not_yet", car_present[2], 1'b0);
      if (k == 6) chk("bounce_present", car_present, 4'b0100);
    end
    chk("bounce_arrive_count", pulses, 1);
    car_raw[2] = 1'b0;
    repeat (10) @(negedge clock);

    // Reset in the middle of a debounce count discards it.
    car_raw[1] = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    car_raw[1] = 1'b0;
    pulses = 0;
    repeat (10) begin @(negedge clock); pulses += int'(car_arrive[1]); end
    chk("rst_mid_no_pulse", pulses, 0);

    // Stuck car4 (index 3): fault 20 cycles after present rises.
    car_raw[3] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clock);
      if (k == 6)  chk("stuck_present", car_present, 4'b1000);
      if (k == 25) chk("stuck_not_yet", stuck_fault, 4'h0);
      if (k == 26) chk("stuck_set", stuck_fault, 4'b1000);
    end
    car_raw[3] = 1'b0;
    repeat (10) @(negedge clock);
    chk("stuck_forces_present", car_present, 4'b1000);
    chk("stuck_sticky", stuck_fault, 4'b1000);
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
    chk("clr_stuck", stuck_fault, 4'h0);
    chk("clr_present", car_present, 4'h0);

    // fault_clr coincides with car2 terminal count: clear wins.
    car_raw[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 25) fault_clr = 1'b1;
      if (k == 26) begin
        fault_clr = 1'b0;
        chk("coincide_clear_wins", stuck_fault, 4'h0);
        chk("coincide_present", car_present, 4'b0010);
      end
    end
    chk("coincide_restart", stuck_fault, 4'h0);
    car_raw[1] = 1'b0;
    repeat (10) @(negedge clock);
    chk("coincide_final", {car_present, stuck_fault}, 0);

    // All four cars stepped together.
    car_raw = 4'hF;
    repeat (6) @(negedge clock);
    chk("simul_arrive", car_arrive, 4'hF);
    car_raw = 4'h0;
    repeat (10) @(negedge clock);
    chk("simul_released", car_present, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
